// File: rtl/aes_axi4_pkg.sv
// Shared constants and FSM state types for the AXI4 burst memory slave.
package aes_axi4_pkg;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;
endpackage

// File: rtl/aes_axi4_burst_slave_if.sv
// AXI4 write/read channel bundle between a burst master and the memory slave.
interface aes_axi4_burst_slave_if #(parameter int ADDR_W = 8);
    logic [ADDR_W-1:0] AWADDR;
    logic [7:0]        AWLEN;
    logic [1:0]        AWBURST;
    logic              AWVALID;
    logic              AWREADY;
    logic [31:0]       WDATA;
    logic [3:0]        WSTRB;
    logic              WLAST;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic [7:0]        ARLEN;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    modport slave (
        input  AWADDR, AWLEN, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
        input  ARADDR, ARLEN, ARBURST, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RLAST, RVALID
    );
    modport master (
        output AWADDR, AWLEN, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
        output ARADDR, ARLEN, ARBURST, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/aes_axi4_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts; flags illegal descriptors,
// which then advance as INCR.
module aes_axi4_addr_gen
    import aes_axi4_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic [AW-1:0] addr,
    input  logic [7:0]    len,
    input  logic [1:0]    burst,
    output logic [AW-1:0] next_addr,
    output logic          err
);
    logic          wrap_len_ok;
    logic [AW-1:0] mask;
    logic [AW-1:0] incr;

    assign wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    // (len+1)*4 - 1 is the window mask when len+1 is a power of two
    assign mask        = AW'({len, 2'b11});
    assign incr        = addr + AW'(4);

    always_comb begin
        err       = ((burst == BURST_WRAP) && !wrap_len_ok) || (burst == BURST_RSVD);
        next_addr = incr;
        if (burst == BURST_FIXED)
            next_addr = addr;
        else if (burst == BURST_WRAP && wrap_len_ok)
            next_addr = (addr & ~mask) | (incr & mask);
    end
endmodule

// File: rtl/aes_axi4_burst_slave.sv
// AXI4 burst memory slave: independent write and read FSMs over a word array
// with byte strobes; read loads see pre-write data on same-cycle collisions.
module aes_axi4_burst_slave
    import aes_axi4_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    aes_axi4_burst_slave_if.slave  s_axi
);
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int DEPTH = 1 << (AW - 2);

    logic [31:0] mem [DEPTH];

    w_state_t    w_state;
    logic [AW-1:0] w_addr, w_next;
    logic [7:0]  w_len, w_cnt;
    logic [1:0]  w_burst;
    logic        w_err, w_derr;
    logic        aw_fire, w_fire, w_last_beat;

    assign s_axi.AWREADY = (w_state == W_IDLE);
    assign s_axi.WREADY  = (w_state == W_DATA);
    assign s_axi.BVALID  = (w_state == W_RESP);
    assign s_axi.BRESP   = (w_state == W_RESP && w_err) ? RESP_SLVERR : RESP_OKAY;

    assign aw_fire     = s_axi.AWVALID && (w_state == W_IDLE);
    assign w_fire      = s_axi.WVALID && (w_state == W_DATA);
    assign w_last_beat = (w_cnt == w_len);

    aes_axi4_addr_gen #(.AW(AW)) u_wgen (
        .addr(w_addr), .len(w_len), .burst(w_burst), .next_addr(w_next), .err(w_derr)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (aw_fire) begin
                    w_addr  <= s_axi.AWADDR;
                    w_len   <= s_axi.AWLEN;
                    w_burst <= s_axi.AWBURST;
                    w_cnt   <= '0;
                    w_err   <= 1'b0;
                    w_state <= W_DATA;
                end
                W_DATA: if (w_fire) begin
                    w_addr  <= w_next;
                    w_cnt   <= w_cnt + 8'd1;
                    w_err   <= w_err | w_derr | (s_axi.WLAST != w_last_beat);
                    if (w_last_beat) w_state <= W_RESP;
                end
                W_RESP: if (s_axi.BREADY) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Reset gates the store so a beat offered in the reset cycle is dropped
    always_ff @(posedge ACLK) begin
        if (w_fire && !ARESET) begin
            for (int b = 0; b < 4; b++)
                if (s_axi.WSTRB[b]) mem[w_addr[AW-1:2]][b*8 +: 8] <= s_axi.WDATA[b*8 +: 8];
        end
    end

    r_state_t    r_state;
    logic [AW-1:0] r_addr, r_next, g_addr;
    logic [7:0]  r_len, r_cnt, g_len;
    logic [1:0]  r_burst, g_burst;
    logic        r_derr, ar_fire, r_fire;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        rlast_q, rvalid_q;

    assign s_axi.ARREADY = (r_state == R_IDLE);
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RRESP   = rresp_q;
    assign s_axi.RLAST   = rlast_q;
    assign s_axi.RVALID  = rvalid_q;

    assign ar_fire = s_axi.ARVALID && (r_state == R_IDLE);
    assign r_fire  = rvalid_q && s_axi.RREADY;

    // r_addr holds the address of the next beat to load; in idle the
    // generator looks at the incoming descriptor so beat 1's address is ready
    assign g_addr  = (r_state == R_IDLE) ? s_axi.ARADDR  : r_addr;
    assign g_len   = (r_state == R_IDLE) ? s_axi.ARLEN   : r_len;
    assign g_burst = (r_state == R_IDLE) ? s_axi.ARBURST : r_burst;

    aes_axi4_addr_gen #(.AW(AW)) u_rgen (
        .addr(g_addr), .len(g_len), .burst(g_burst), .next_addr(r_next), .err(r_derr)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state  <= R_IDLE;
            r_addr   <= '0;
            r_len    <= '0;
            r_burst  <= '0;
            r_cnt    <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rlast_q  <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: if (ar_fire) begin
                    r_addr   <= r_next;
                    r_len    <= s_axi.ARLEN;
                    r_burst  <= s_axi.ARBURST;
                    r_cnt    <= '0;
                    rdata_q  <= mem[g_addr[AW-1:2]];
                    rresp_q  <= r_derr ? RESP_SLVERR : RESP_OKAY;
                    rlast_q  <= (s_axi.ARLEN == 8'd0);
                    rvalid_q <= 1'b1;
                    r_state  <= R_DATA;
                end
                R_DATA: if (r_fire) begin
                    if (rlast_q) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        r_state  <= R_IDLE;
                    end else begin
                        rdata_q <= mem[g_addr[AW-1:2]];
                        r_addr  <= r_next;
                        r_cnt   <= r_cnt + 8'd1;
                        rlast_q <= ((r_cnt + 8'd1) == r_len);
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule
